// File: rtl/mc_main_ctrl.sv
// Main control FSM for the multicycle MIPS datapath, with a ready-based memory handshake and timeout.
// Optional performance counters (cycle_cnt, instr_cnt) are present when MC_MAIN_CTRL_PERF_CNT_EN is defined.
module mc_main_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        is_imm,
    output logic [3:0]  exe_cmd,
    output logic        wb_en,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        illegal_instr,
    output logic        bus_error,
    output logic [3:0]  state
`ifdef MC_MAIN_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW   = 6'b100011, OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010, OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] CMD_ADD = 4'b0000, CMD_SUB = 4'b0010, CMD_AND = 4'b0100, CMD_OR  = 4'b0101;
    localparam logic [3:0] CMD_NOR = 4'b0110, CMD_XOR = 4'b0111, CMD_SLL = 4'b1000, CMD_SRA = 4'b1001;
    localparam logic [3:0] CMD_SRL = 4'b1010, CMD_SLT = 4'b1100;

    localparam int              WAIT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam bit              TO_EN    = (MEM_TIMEOUT > 0);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic [5:0] opcode, funct;
    logic       is_rtype, r_ok, mem_state, timeout;
    logic [3:0] r_cmd, i_cmd;
    logic       ir_write_raw, iord_raw, mem_r_en_raw, mem_w_en_raw, pc_write_raw;
    logic [1:0] pc_src_raw;
    logic       is_imm_raw, wb_en_raw, mem_to_reg_raw, reg_dst_raw, illegal_raw, bus_error_raw;
    logic [3:0] exe_cmd_raw;
    logic       unused_instr;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign is_rtype     = (opcode == OP_RTYPE);
    assign unused_instr = &{1'b0, instr[25:6]};

    always_comb begin
        r_ok  = 1'b1;
        r_cmd = CMD_ADD;
        case (funct)
            6'b100000, 6'b100001: r_cmd = CMD_ADD;
            6'b100010, 6'b100011: r_cmd = CMD_SUB;
            6'b100100:            r_cmd = CMD_AND;
            6'b100101:            r_cmd = CMD_OR;
            6'b100111:            r_cmd = CMD_NOR;
            6'b100110:            r_cmd = CMD_XOR;
            6'b000000:            r_cmd = CMD_SLL;
            6'b000011:            r_cmd = CMD_SRA;
            6'b000010:            r_cmd = CMD_SRL;
            6'b101010:            r_cmd = CMD_SLT;
            default:              r_ok  = 1'b0;
        endcase
    end

    always_comb begin
        i_cmd = CMD_ADD;
        case (opcode)
            OP_ANDI: i_cmd = CMD_AND;
            OP_ORI:  i_cmd = CMD_OR;
            OP_SLTI: i_cmd = CMD_SLT;
            default: i_cmd = CMD_ADD;
        endcase
    end

    // Completion wins over timeout: the threshold only fires when mem_ready is low.
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign timeout   = TO_EN && mem_state && !mem_ready && (wait_q == WAIT_MAX);

    always_comb begin
        state_d        = state_q;
        ir_write_raw   = 1'b0;
        iord_raw       = 1'b0;
        mem_r_en_raw   = 1'b0;
        mem_w_en_raw   = 1'b0;
        pc_write_raw   = 1'b0;
        pc_src_raw     = 2'b00;
        is_imm_raw     = 1'b0;
        exe_cmd_raw    = CMD_ADD;
        wb_en_raw      = 1'b0;
        mem_to_reg_raw = 1'b0;
        reg_dst_raw    = 1'b0;
        illegal_raw    = 1'b0;
        bus_error_raw  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (timeout) begin
                    bus_error_raw = 1'b1;
                    state_d       = S_FETCH;
                end else begin
                    mem_r_en_raw = 1'b1;
                    if (mem_ready) begin
                        ir_write_raw = 1'b1;
                        pc_write_raw = 1'b1;
                        state_d      = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
                    OP_J:                              state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (r_ok) begin
                            state_d = S_EXECUTE;
                        end else begin
                            illegal_raw = 1'b1;
                            state_d     = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_raw = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                is_imm_raw  = 1'b1;
                exe_cmd_raw = CMD_ADD;
                state_d     = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                iord_raw = 1'b1;
                if (timeout) begin
                    bus_error_raw = 1'b1;
                    state_d       = S_FETCH;
                end else begin
                    mem_r_en_raw = 1'b1;
                    if (mem_ready) state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                wb_en_raw      = 1'b1;
                mem_to_reg_raw = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WRITE: begin
                iord_raw = 1'b1;
                if (timeout) begin
                    bus_error_raw = 1'b1;
                    state_d       = S_FETCH;
                end else begin
                    mem_w_en_raw = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                is_imm_raw  = !is_rtype;
                exe_cmd_raw = is_rtype ? r_cmd : i_cmd;
                state_d     = S_ALU_WB;
            end
            S_ALU_WB: begin
                wb_en_raw   = 1'b1;
                reg_dst_raw = is_rtype;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                exe_cmd_raw  = CMD_SUB;
                pc_src_raw   = 2'b01;
                pc_write_raw = (opcode == OP_BNE) ? !zero : zero;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                pc_src_raw   = 2'b10;
                pc_write_raw = 1'b1;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        wait_d = wait_q;
        if ((state_d != state_q) || timeout) begin
            wait_d = '0;
        end else if (TO_EN && mem_state && !mem_ready) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Reset gates every enable combinationally so an in-flight write-back is cut off at once.
    assign ir_write      = rst & ir_write_raw;
    assign iord          = rst & iord_raw;
    assign mem_r_en      = rst & mem_r_en_raw;
    assign mem_w_en      = rst & mem_w_en_raw;
    assign pc_write      = rst & pc_write_raw;
    assign pc_src        = rst ? pc_src_raw : 2'b00;
    assign is_imm        = rst & is_imm_raw;
    assign exe_cmd       = rst ? exe_cmd_raw : 4'b0000;
    assign wb_en         = rst & wb_en_raw;
    assign mem_to_reg    = rst & mem_to_reg_raw;
    assign reg_dst       = rst & reg_dst_raw;
    assign illegal_instr = rst & illegal_raw;
    assign bus_error     = rst & bus_error_raw;
    assign state         = state_q;

`ifdef MC_MAIN_CTRL_PERF_CNT_EN
    logic        instr_done;
    logic [31:0] cycle_cnt_q, instr_cnt_q;

    assign instr_done = (state_d == S_FETCH) && !timeout &&
                        ((state_q == S_MEM_WB) || (state_q == S_MEM_WRITE) || (state_q == S_ALU_WB) ||
                         (state_q == S_BRANCH) || (state_q == S_JUMP));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (instr_done) instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. Sequences fetch, decode, execute, memory and write-back for one instruction at a time, driving register-file, ALU, PC and memory enables. Sits beside the ID/EXE logic and consumes the IR contents plus the ALU zero flag. Handles a ready-based memory handshake with timeout.

Parameters:
MEM_TIMEOUT, 15, max wait cycles for mem_ready per access; 0 disables timeout.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
instr  in  32  IR output, stable from DECODE onward
zero  in  1  ALU zero flag, valid in BRANCH
mem_ready  in  1  memory access complete this cycle
ir_write  out  1  load IR from memory data
iord  out  1  0 = PC addresses memory, 1 = ALU result
mem_r_en  out  1  memory read request
mem_w_en  out  1  memory write request
pc_write  out  1  PC load enable
pc_src  out  2  00 PC+4, 01 branch target, 10 jump target
is_imm  out  1  ALU operand B = sign-extended immediate
exe_cmd  out  4  ALU command
wb_en  out  1  register-file write enable
mem_to_reg  out  1  write-back data from memory (1) or ALU (0)
reg_dst  out  1  dest = rd (1) or rt (0)
illegal_instr  out  1  one-cycle pulse on unsupported opcode/funct
bus_error  out  1  one-cycle pulse on memory timeout
state  out  4  current state code, for debug

Behaviour:
- rst=0: state=FETCH, wait counter=0, all outputs 0 (enables gated by rst). First active FETCH cycle is the first clk edge after release.
- States (code): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JUMP 9. Moore outputs, except pc_write in BRANCH and the handshake-qualified enables.
- FETCH: mem_r_en=1, iord=0. When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, go to DECODE. Otherwise stay.
- DECODE: opcode=instr[31:26], funct=instr[5:0].
  - 100011 lw or 101011 sw -> MEM_ADDR.
  - 000000 R-type, addi 001000, andi 001100, ori 001101, slti 001010 -> EXECUTE.
  - beq 000100 or bne 000101 -> BRANCH.
  - j 000010 -> JUMP.
  - Anything else, including unsupported funct: illegal_instr=1 for one cycle, go to FETCH.
- MEM_ADDR: is_imm=1, exe_cmd=ADD. lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ: mem_r_en=1, iord=1 until mem_ready, then MEM_WB.
- MEM_WB: wb_en=1, mem_to_reg=1, reg_dst=0, then FETCH.
- MEM_WRITE: mem_w_en=1, iord=1 until mem_ready, then FETCH.
- EXECUTE: R-type uses is_imm=0 and exe_cmd from funct. I-type uses is_imm=1 and exe_cmd from opcode. Next state ALU_WB.
- ALU_WB: wb_en=1, mem_to_reg=0, reg_dst=1 for R-type else 0, then FETCH.
- BRANCH: exe_cmd=SUB, pc_src=01, pc_write = zero (beq) or !zero (bne), then FETCH.
- JUMP: pc_src=10, pc_write=1, then FETCH.
- exe_cmd encoding: ADD 0000, SUB 0010, AND 0100, OR 0101, NOR 0110, XOR 0111, SLL 1000, SRA 1001, SRL 1010, SLT 1100.
  - Funct map: 100000/100001 ADD, 100010/100011 SUB, 100100 AND, 100101 OR, 100111 NOR, 100110 XOR, 000000 SLL, 000011 SRA, 000010 SRL, 101010 SLT.
- Latency with zero-wait memory: R/I-ALU 4, lw 5, sw 4, beq/bne 3, j 3 cycles. Each memory wait cycle adds 1.
- Timeout:
  - Wait counter clears on entering any memory state and increments each cycle mem_ready=0.
  - If the count reaches MEM_TIMEOUT (MEM_TIMEOUT>0), deassert the request, pulse bus_error, go to FETCH.
  - A timed-out fetch performs no ir_write or pc_write.
- mem_ready on the same cycle as the timeout threshold: completion wins, no bus_error.
- mem_ready outside memory states: ignored.
- rst asserted mid-instruction: immediate return to FETCH with outputs 0. No partial write-back completes.

Optional Feature:
MC_MAIN_CTRL_PERF_CNT_EN
- Defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle out of reset.
  - instr_cnt increments on each transition to FETCH from MEM_WB, MEM_WRITE, ALU_WB, BRANCH or JUMP. Illegal and timed-out instructions are not counted.
  - Both wrap at 2^32.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Release rst, mem_ready=1, instr=0x012A4020 (add $8,$9,$10) -> states 0,1,6,7,0. exe_cmd=0000, wb_en=1 with reg_dst=1 in state 7.
- lw 0x8D280004, mem_ready low for 2 cycles in MEM_READ -> 7 cycles total, mem_to_reg=1 and wb_en=1 in MEM_WB.
- beq 0x11090003 with zero=1, then zero=0 -> pc_write=1, pc_src=01 in BRANCH; then pc_write=0.
- j 0x08000010 -> pc_write=1, pc_src=10 in state 9; instr opcode 111111 -> illegal_instr pulse, back to FETCH, no wb_en.
- MEM_TIMEOUT=3, mem_ready held 0 in FETCH -> bus_error pulse after 3 wait cycles, no ir_write/pc_write, FETCH re-entered.
- rst driven low during MEM_WB -> wb_en drops immediately, state=0; with MC_MAIN_CTRL_PERF_CNT_EN, instr_cnt=0 afterwards.
